// File: rtl/shared_dmem_arbiter_pkg.sv
// Shared definitions for the shared data-memory arbiter.
//   arb_state_e : sequencer states (IDLE -> ACCESS -> WAIT -> DONE -> IDLE)
//   DEF_AW/DW   : default address and data widths
//   rr_index()  : position in the round-robin scan starting at a base core
package shared_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_WAIT   = 2'b10,
        ARB_DONE   = 2'b11
    } arb_state_e;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    // Core index visited at step 'offset' of a scan that begins at 'base'.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/shared_dmem_arbiter_if.sv
// Bus between NCORES cores, the arbiter and the single-port data RAM.
//   Core side : req, we, addr, wdata (in) / grant, done, rdata (out)
//   RAM side  : mem_en, mem_we, mem_addr, mem_wdata (out) / mem_rdata (in)
// Modport slave is the arbiter; modport master is the cores plus the RAM.
interface shared_dmem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);
    logic [NCORES-1:0]    req;
    logic [NCORES-1:0]    we;
    logic [NCORES*AW-1:0] addr;
    logic [NCORES*DW-1:0] wdata;
    logic [NCORES-1:0]    grant;
    logic [NCORES-1:0]    done;
    logic [DW-1:0]        rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic [DW-1:0]        mem_rdata;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output grant, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  grant, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/shared_dmem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-core request vector
//   ptr    : core with highest priority this round
//   onehot : selected core as a one-hot vector
//   idx    : selected core as an index
//   any    : at least one request present
module shared_dmem_arbiter_rr_pick
    import shared_dmem_arbiter_pkg::*;
#(
    parameter int NCORES = 4,
    parameter int IW     = 2
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NCORES-1:0] onehot,
    output logic [IW-1:0]     idx,
    output logic              any
);

    // Scan ptr, ptr+1, ... and keep the first requesting core.
    always_comb begin
        logic hit;
        int   c;
        onehot = {NCORES{1'b0}};
        idx    = {IW{1'b0}};
        any    = 1'b0;
        hit    = 1'b0;
        c      = 0;
        for (int k = 0; k < NCORES; k++) begin
            c         = rr_index(int'(ptr), k, NCORES);
            hit       = !any && req[c];
            onehot[c] = hit;
            idx       = hit ? IW'(c) : idx;
            any       = any | hit;
        end
    end

endmodule

// File: rtl/shared_dmem_arbiter.sv
// Round-robin sequencer sharing one single-port data RAM between NCORES cores.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : core requests/responses and RAM control (slave modport)
// Each access runs IDLE -> ACCESS -> WAIT (MEM_LAT cycles) -> DONE. Requests are
// only looked at in IDLE; the winning core's address, data and write select are
// latched there and held for the whole transaction. All outputs are registered.
module shared_dmem_arbiter
    import shared_dmem_arbiter_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shared_dmem_arbiter_if.slave bus
);

    localparam int            IW       = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int            CW       = 2;
    localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCORES - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1'b1);

    arb_state_e        state_r, state_nxt_s;
    logic [IW-1:0]     ptr_r, ptr_nxt_s;
    logic [CW-1:0]     cnt_r, cnt_nxt_s;
    logic              is_wr_r, is_wr_nxt_s;
    logic [NCORES-1:0] grant_r, grant_nxt_s;
    logic [NCORES-1:0] done_r, done_nxt_s;
    logic [DW-1:0]     rdata_r, rdata_nxt_s;
    logic              mem_en_r, mem_en_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [AW-1:0]     mem_addr_r, mem_addr_nxt_s;
    logic [DW-1:0]     mem_wdata_r, mem_wdata_nxt_s;

    logic [NCORES-1:0] pick_onehot_s;
    logic [IW-1:0]     pick_idx_s;
    logic              pick_any_s;

    shared_dmem_arbiter_rr_pick #(
        .NCORES (NCORES),
        .IW     (IW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) state_nxt_s = ARB_ACCESS;
                else            state_nxt_s = ARB_IDLE;
            end
            ARB_ACCESS: state_nxt_s = ARB_WAIT;
            ARB_WAIT: begin
                if (cnt_r == CNT_ZERO) state_nxt_s = ARB_DONE;
                else                   state_nxt_s = ARB_WAIT;
            end
            ARB_DONE: state_nxt_s = ARB_IDLE;
            default:  state_nxt_s = ARB_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and wait counter.
    // mem_en/mem_we/done default low so each is a single-cycle pulse.
    always_comb begin
        ptr_nxt_s       = ptr_r;
        cnt_nxt_s       = cnt_r;
        is_wr_nxt_s     = is_wr_r;
        grant_nxt_s     = grant_r;
        done_nxt_s      = {NCORES{1'b0}};
        rdata_nxt_s     = rdata_r;
        mem_en_nxt_s    = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    grant_nxt_s     = pick_onehot_s;
                    mem_addr_nxt_s  = bus.addr[pick_idx_s*AW +: AW];
                    mem_wdata_nxt_s = bus.wdata[pick_idx_s*DW +: DW];
                    is_wr_nxt_s     = bus.we[pick_idx_s];
                    mem_we_nxt_s    = bus.we[pick_idx_s];
                    mem_en_nxt_s    = 1'b1;
                    // Winner drops to lowest priority for the next round.
                    ptr_nxt_s       = (pick_idx_s == LAST_IDX) ? {IW{1'b0}} : pick_idx_s + IDX_ONE;
                end else begin
                    grant_nxt_s     = grant_r;
                end
            end
            ARB_ACCESS: cnt_nxt_s = LAT_LOAD;
            ARB_WAIT: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    done_nxt_s = grant_r;
                    // Writes leave the last read value on rdata.
                    if (!is_wr_r) rdata_nxt_s = bus.mem_rdata;
                    else          rdata_nxt_s = rdata_r;
                end
            end
            ARB_DONE: grant_nxt_s = {NCORES{1'b0}};
            default:  grant_nxt_s = {NCORES{1'b0}};
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r       <= {IW{1'b0}};
            cnt_r       <= CNT_ZERO;
            is_wr_r     <= 1'b0;
            grant_r     <= {NCORES{1'b0}};
            done_r      <= {NCORES{1'b0}};
            rdata_r     <= {DW{1'b0}};
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
        end else begin
            ptr_r       <= ptr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            is_wr_r     <= is_wr_nxt_s;
            grant_r     <= grant_nxt_s;
            done_r      <= done_nxt_s;
            rdata_r     <= rdata_nxt_s;
            mem_en_r    <= mem_en_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    assign bus.grant     = grant_r;
    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
module tb_shared_dmem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LAT1 = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_dmem_arbiter_if #(.NCORES(N), .AW(AW), .DW(DW)) bus ();
    shared_dmem_arbiter_if #(.NCORES(N), .AW(AW), .DW(DW)) bus3 ();

    shared_dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    shared_dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        if (a == 8'h3C) return 8'h5A;
        return (a * 8'd13) ^ 8'hC5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- RAM models (environment) ----------------
    logic [7:0] ram  [256];
    logic [7:0] ram3 [256];
    logic [7:0] rd1_r = 8'h00;
    logic [7:0] p3 [3] = '{8'h00, 8'h00, 8'h00};
    assign bus.mem_rdata  = rd1_r;
    assign bus3.mem_rdata = p3[2];

    initial begin : ram1
        for (int i = 0; i < 256; i++) ram[i] = init_val(8'(i));
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                rd1_r <= ram[bus.mem_addr];
                if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
            end
        end
    end

    initial begin : ramlat3
        for (int i = 0; i < 256; i++) ram3[i] = init_val(8'(i)) ^ 8'hFF;
        forever begin
            @(posedge clk);
            p3[0] <= bus3.mem_en ? ram3[bus3.mem_addr] : p3[0];
            p3[1] <= p3[0];
            p3[2] <= p3[1];
        end
    end

    // ---------------- reference model + scoreboard queues ----------------
    typedef struct { int core; logic [7:0] rdata; int due; } done_t;
    typedef struct { logic [7:0] addr; logic we; logic [7:0] wdata; int due; } acc_t;
    done_t dq[$];
    acc_t  aq[$];
    logic [7:0] ref_mem [256];

    // One transaction at a time; the arbiter is busy for 2+LAT edges after a grant
    // and the next decision uses the rotating priority of the last winner + 1.
    initial begin : model
        int mptr, mbusy, g;
        logic [7:0] mlast, a, wd;
        logic w;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        mptr = 0; mbusy = 0; mlast = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                dq.delete(); aq.delete();
                mptr = 0; mbusy = 0; mlast = 8'h00;
            end else if (mbusy > 0) begin
                mbusy--;
            end else if (bus.req != 4'b0000) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req[(mptr + k) % N]) g = (mptr + k) % N;
                a  = bus.addr[g*AW +: AW];
                wd = bus.wdata[g*DW +: DW];
                w  = bus.we[g];
                aq.push_back('{addr: a, we: w, wdata: wd, due: cyc});
                if (w) ref_mem[a] = wd;
                else   mlast = ref_mem[a];
                dq.push_back('{core: g, rdata: mlast, due: cyc + 1 + LAT1});
                mptr  = (g + 1) % N;
                mbusy = 2 + LAT1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        acc_t  ea;
        done_t ed;
        forever begin
            @(negedge clk);
            chk("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
            chk("we_implies_en", 32'(!bus.mem_we || bus.mem_en), 32'd1);
            if (bus.mem_en) begin
                if (aq.size() == 0) begin
                    chk("unexpected_access", 32'd1, 32'd0);
                end else begin
                    ea = aq.pop_front();
                    chk("acc_addr", 32'(bus.mem_addr), 32'(ea.addr));
                    chk("acc_we", 32'(bus.mem_we), 32'(ea.we));
                    if (ea.we) chk("acc_wdata", 32'(bus.mem_wdata), 32'(ea.wdata));
                    chk("acc_cycle", 32'(cyc), 32'(ea.due));
                end
            end else if (aq.size() > 0 && aq[0].due < cyc) begin
                ea = aq.pop_front();
                chk("missing_access", 32'(cyc), 32'(ea.due));
            end
            if (bus.done != 4'b0000) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    ed = dq.pop_front();
                    chk("done_core", 32'(bus.done), 32'(4'b0001 << ed.core));
                    chk("done_grant", 32'(bus.grant), 32'(4'b0001 << ed.core));
                    chk("done_rdata", 32'(bus.rdata), 32'(ed.rdata));
                    chk("done_cycle", 32'(cyc), 32'(ed.due));
                end
            end else if (dq.size() > 0 && dq[0].due < cyc) begin
                ed = dq.pop_front();
                chk("missing_done", 32'(cyc), 32'(ed.due));
            end
        end
    end

    // ---------------- core-side stimulus ----------------
    logic [N-1:0] pend = 4'b0000;
    logic [N-1:0] pwe  = 4'b0000;
    logic [7:0]   paddr  [N];
    logic [7:0]   pwdata [N];
    bit hold_all = 1'b0;
    bit rnd      = 1'b0;

    task automatic drive();
        bus.req = pend;
        bus.we  = pwe;
        for (int i = 0; i < N; i++) begin
            bus.addr[i*AW +: AW]  = paddr[i];
            bus.wdata[i*DW +: DW] = pwdata[i];
        end
    endtask

    task automatic start(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
        pend[i] = 1'b1; pwe[i] = w; paddr[i] = a; pwdata[i] = d;
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.done[i]) pend[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hold_all && !pend[i])
                start(i, 1'b0, 8'(8'h20 + i), 8'h00);
            else if (rnd && !pend[i] && $urandom_range(0, 2) == 0)
                start(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
        end
        drive();
    endtask

    task automatic wait_done(input string name, output logic [3:0] d);
        int n = 0;
        d = 4'b0000;
        while (n < 40 && d == 4'b0000) begin
            tick();
            d = bus.done;
            n++;
        end
        if (d == 4'b0000) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (pend != 4'b0000 && n < 300) begin tick(); n++; end
        chk("drain", 32'(pend), 32'd0);
        repeat (4) tick();
    endtask

    logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin : stim
        logic [3:0] d;
        int c0, last_c, n;
        for (int i = 0; i < N; i++) begin paddr[i] = 8'h00; pwdata[i] = 8'h00; end
        bus3.req = 4'b0000; bus3.we = 4'b0000; bus3.addr = 32'h0; bus3.wdata = 32'h0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) start(i, 1'b0, 8'(8'h20 + i), 8'h00);
        tick(); tick();
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        rst_n = 1'b1;

        // Continuous requests from all cores rotate the grant.
        hold_all = 1'b1;
        last_c = 0;
        for (int k = 0; k < 5; k++) begin
            wait_done("rr", d);
            chk("rr_seq", 32'(d), 32'(rr_exp[k]));
            if (k > 0) chk("rr_spacing", 32'(cyc - last_c), 32'd4);
            last_c = cyc;
        end
        hold_all = 1'b0;
        drain();

        // Single read: core 2, 0x3C holds 0x5A.
        c0 = cyc;
        start(2, 1'b0, 8'h3C, 8'h00);
        wait_done("rd", d);
        chk("rd_done", 32'(d), 32'b0100);
        chk("rd_data", 32'(bus.rdata), 32'h5A);
        chk("rd_latency", 32'(cyc - c0), 32'd3);
        repeat (2) tick();

        // Single write: core 1 writes 0xA7 to 0x10; rdata keeps 0x5A.
        start(1, 1'b1, 8'h10, 8'hA7);
        wait_done("wr", d);
        chk("wr_done", 32'(d), 32'b0010);
        chk("wr_rdata_kept", 32'(bus.rdata), 32'h5A);
        repeat (2) tick();
        start(0, 1'b0, 8'h10, 8'h00);
        wait_done("rdback", d);
        chk("rdback_done", 32'(d), 32'b0001);
        chk("rdback_data", 32'(bus.rdata), 32'hA7);
        repeat (2) tick();

        // ptr is 1 here: req 1001 serves core 3 before core 0.
        start(0, 1'b0, 8'h01, 8'h00);
        start(3, 1'b0, 8'h02, 8'h00);
        wait_done("skip1", d);
        chk("skip_first", 32'(d), 32'b1000);
        wait_done("skip2", d);
        chk("skip_second", 32'(d), 32'b0001);
        repeat (2) tick();

        // Reset during WAIT of a read aborts it; pointer returns to 0.
        start(3, 1'b0, 8'h05, 8'h00);
        n = 0;
        while (!bus.mem_en && n < 10) begin tick(); n++; end
        chk("abort_saw_access", 32'(bus.mem_en), 32'd1);
        tick();
        rst_n = 1'b0;
        pend = 4'b0000;
        drive();
        tick();
        chk("abort_grant", 32'(bus.grant), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rdata", 32'(bus.rdata), 32'd0);
        rst_n = 1'b1;
        start(1, 1'b0, 8'h06, 8'h00);
        start(3, 1'b0, 8'h07, 8'h00);
        wait_done("abort1", d);
        chk("abort_next_core1", 32'(d), 32'b0010);
        wait_done("abort2", d);
        chk("abort_then_core3", 32'(d), 32'b1000);
        drain();

        // Randomised traffic checked by the scoreboard.
        rnd = 1'b1;
        repeat (400) tick();
        rnd = 1'b0;
        drain();

        // MEM_LAT=3 instance: read core 0, addr 0x07; done 5 edges after issue.
        @(negedge clk);
        bus3.addr[7:0] = 8'h07;
        bus3.req = 4'b0001;
        c0 = cyc;
        n = 0;
        while (bus3.done == 4'b0000 && n < 20) begin @(negedge clk); n++; end
        bus3.req = 4'b0000;
        chk("lat3_done", 32'(bus3.done), 32'b0001);
        chk("lat3_latency", 32'(cyc - c0), 32'd5);
        chk("lat3_rdata", 32'(bus3.rdata), 32'(init_val(8'h07) ^ 8'hFF));
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
